// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: one shared edge- or center-aligned counter, per-channel
// debounced duty buttons, and duty/mode changes that take effect only at period boundaries.
module pwm_gen_multi #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 4,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 5,
    parameter int DB_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      center_mode,
    input  logic [CHANNELS-1:0]       increase_duty,
    input  logic [CHANNELS-1:0]       decrease_duty,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic [CHANNELS*CNT_W-1:0] duty_o
);
    localparam int NB   = 2 * CHANNELS;
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] PER_V  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] TOP_V  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] TURN_V = CNT_W'(PERIOD - 2);
    localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(DUTY_INIT);
    localparam logic [DB_W-1:0]  DB_V   = DB_W'(DB_CYCLES);

    logic [NB-1:0]                 btn;
    logic [NB-1:0]                 sync1_q, sync2_q;
    logic [NB-1:0]                 acc_q, acc_d, accDly_q, press_q;
    logic [NB-1:0][DB_W-1:0]       dbCnt_q, dbCnt_d;
    logic [CHANNELS-1:0][CNT_W-1:0] pend_q, pend_d, active_q, active_d, dutyEff;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          up_q, up_d, mode_q, mode_d, tick_q, tick_d;
    logic [CHANNELS-1:0]           pwm_q, pwm_d;
    logic                          boundary;

    // Buttons 0..CHANNELS-1 are increase, CHANNELS..NB-1 are decrease.
    assign btn = {decrease_duty, increase_duty};

    // The accepted level flips only after the counter has saturated and the level still differs.
    always_comb begin
        acc_d   = acc_q;
        dbCnt_d = '0;
        for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] != acc_q[b]) begin
                if (dbCnt_q[b] == DB_V) acc_d[b] = ~acc_q[b];
                else                    dbCnt_d[b] = dbCnt_q[b] + DB_W'(1);
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (press_q[i] && !press_q[CHANNELS+i])
                pend_d[i] = (pend_q[i] >= PER_V - STEP_V) ? PER_V : pend_q[i] + STEP_V;
            else if (!press_q[i] && press_q[CHANNELS+i])
                pend_d[i] = (pend_q[i] <= STEP_V) ? '0 : pend_q[i] - STEP_V;
        end
    end

    assign boundary = (cnt_q == '0);
    // At a boundary the freshly loaded duty already governs the count-0 compare.
    assign dutyEff  = boundary ? pend_q : active_q;

    always_comb begin
        cnt_d    = cnt_q;
        up_d     = up_q;
        mode_d   = mode_q;
        active_d = active_q;
        pwm_d    = '0;
        tick_d   = 1'b0;
        if (!enable) begin
            cnt_d    = '0;
            up_d     = 1'b1;
            mode_d   = center_mode;
            active_d = pend_q;
        end else begin
            tick_d = boundary;
            for (int i = 0; i < CHANNELS; i++) pwm_d[i] = (cnt_q < dutyEff[i]);
            if (boundary) begin
                mode_d   = center_mode;
                active_d = pend_q;
                cnt_d    = CNT_W'(1);
                up_d     = 1'b1;
            end else if (!mode_q) begin
                cnt_d = (cnt_q == TOP_V) ? '0 : cnt_q + CNT_W'(1);
                up_d  = 1'b1;
            end else if (up_q) begin
                if (cnt_q == TOP_V) begin
                    cnt_d = TURN_V;
                    up_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            acc_q    <= '0;
            accDly_q <= '0;
            press_q  <= '0;
            dbCnt_q  <= '0;
            pend_q   <= {CHANNELS{INIT_V}};
            active_q <= {CHANNELS{INIT_V}};
            cnt_q    <= '0;
            up_q     <= 1'b1;
            mode_q   <= 1'b0;
            pwm_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            accDly_q <= acc_q;
            press_q  <= acc_q & ~accDly_q;
            dbCnt_q  <= dbCnt_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            up_q     <= up_d;
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign duty_o      = pend_q;
endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Parametrised multi-channel successor to the single-channel button-driven PWM generator. It drives CHANNELS independent PWM outputs from one shared period counter, and supports edge-aligned or center-aligned modes. Each channel has its own debounced increase/decrease buttons, and duty updates are glitch-free because they apply only at period boundaries. It sits directly behind the user-project wrapper, with buttons on io_in and PWM on io_out.

## Interface
- CHANNELS, 2: number of PWM channels.
- CNT_W, 4: width of counter and duty values; must satisfy PERIOD < 2^CNT_W.
- PERIOD, 10: counts per edge-aligned period; legal range ≥ 2.
- STEP, 1: duty change per button press.
- DUTY_INIT, 5: duty after reset, ≤ PERIOD.
- DB_CYCLES, 4: consecutive stable cycles required to accept a button level.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = counter runs; 0 = counter parked.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
- increase_duty  in  CHANNELS  asynchronous button per channel.
- decrease_duty  in  CHANNELS  asynchronous button per channel.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse per period start.
- duty_o  out  CHANNELS*CNT_W  pending duty per channel; channel i at bits [i*CNT_W +: CNT_W].

## Operation
- **Input synchronisation:** each button passes through a 2-FF synchroniser.
- **Debounce:** per button, a counter tracks how long the synchronised level has differed from the accepted level. Once it differs for DB_CYCLES consecutive cycles, the accepted level flips. Any agreeing cycle clears the counter.
- **Press pulse:** a rising edge of the accepted level yields a one-cycle registered press pulse. Falling edges are ignored, so holding a button produces one step.
- **Pending duty update (per channel):**
  - inc pulse alone: pending = min(pending + STEP, PERIOD).
  - dec pulse alone: pending = max(pending − STEP, 0), saturating with no underflow wrap.
  - inc and dec in the same cycle: no change.
- **Active duty:**
  - Loaded from pending at the boundary, i.e. the cycle in which the counter value is 0 and the next count begins a period.
  - Never changes mid-period.
- **Mode latch:** the mode register is loaded from center_mode at the same boundary.
- **Edge mode:** counter runs 0,1,…,PERIOD−1,0,… (period PERIOD cycles).
- **Center mode:** counter runs 0,1,…,PERIOD−1,PERIOD−2,…,1,0,… (period 2·PERIOD−2 cycles). The direction flag flips at PERIOD−1 and at 0.
- **Compare (both modes):** channel high when counter < active duty.
  - duty = 0 → constantly low.
  - duty = PERIOD → constantly high.
- **Mode switch:** the counter restarts at 0 counting up.
- **enable = 0:**
  - Counter held at 0, direction set to up.
  - pwm_out forced low; period_tick low.
  - Active duty and mode reload from pending and center_mode every cycle.
  - Buttons still update pending.
- **enable 0→1:** the first enabled cycle is a boundary with counter = 0.

## Timing
- **Reset values:** counter 0, direction up, mode edge, pending = active = DUTY_INIT, pwm_out all 0, period_tick 0, debounce accepted levels 0, synchronisers 0.
- **Reset mid-operation:** all of the above on the next edge, with no partial period completed.
- **pwm_out latency:** pwm_out[i] is registered and reflects the counter/duty compare one cycle later.
- **period_tick:** asserted the cycle after each enabled boundary, coincident with pwm_out for count 0.
- **Button latency:** with a button held high, duty_o changes on the (DB_CYCLES+4)th rising edge after the edge that first samples it high (2 sync + DB_CYCLES debounce + pulse + pending register).
- **Glitch rejection:** a glitch shorter than DB_CYCLES cycles after synchronisation produces no pulse.
- **Effect on output:** a pending change affects pwm_out starting with the next period (boundary +1 cycle).

## Test plan
- **Reset and idle:** reset low 3 cycles, enable = 1, edge mode, defaults → pwm_out[0] high 5 cycles, low 5 cycles, repeating; period_tick every 10 cycles; duty_o = 5 per channel.
- **Increase and saturate:** hold increase_duty[1] high 10 cycles → duty_o ch1 = 6 at edge DB_CYCLES+4 = 8, ch0 unchanged. Six more presses → ch1 saturates at 10 and pwm_out[1] stays high for a whole period.
- **Decrease and bounce rejection:** dec presses on ch0 → duty floor at 0, pwm_out[0] constantly low. A 3-cycle pulse on decrease_duty[0] → no change.
- **Simultaneous buttons:** inc and dec asserted on the same cycle, ch0 → duty_o unchanged. A press mid-period → the current period's pulse width is unchanged and the next period reflects the new duty.
- **Center mode:** center_mode = 1, duty 5 → period 18 cycles; high 9 cycles (counts 4..0..4) centered on count 0. The switch takes effect only at the boundary.
- **enable / reset mid-period:** enable dropped at count 6 → pwm_out low next cycle, counter parked. Re-enable → period restarts at 0. Reset asserted mid-period → all outputs reset values, duty back to 5.
